// File: rtl/rsa_alu_seq.sv
// Handshaked EXE-stage ALU: add, sub, modular multiply and constant-time modular exponentiation.
// Every modular operation runs on one shared bit-serial interleaved multiplier.
module rsa_alu_seq #(
  parameter int ARQ = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     ALU_Contrl,
  input  logic [ARQ-1:0] data1,
  input  logic [ARQ-1:0] data2,
  input  logic [ARQ-1:0] data3,
  output logic           busy,
  output logic           done,
  output logic [ARQ-1:0] ALU_Result,
  output logic           z,
  output logic           c,
  output logic           v,
  output logic           err
);

  localparam int CW = $clog2(ARQ);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b11;
  localparam logic [CW-1:0] CNT_TOP = CW'(ARQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_MUL, S_EINIT, S_ESQR, S_EMUL, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [ARQ-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, r_q, r_d;
  logic [ARQ+1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d, ecnt_q, ecnt_d;
  logic [ARQ-1:0]   res_q, res_d;
  logic             z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

  logic [ARQ-1:0]   mul_a;
  logic             mul_bit;
  logic [ARQ+1:0]   step;
  logic [ARQ:0]     sum_w, diff_w;

  // One MSB-first interleaved step: acc = 2*acc mod m, then conditionally (acc + a) mod m.
  function automatic logic [ARQ+1:0] mm_step(input logic [ARQ+1:0] acc, input logic [ARQ-1:0] a,
                                             input logic bb, input logic [ARQ-1:0] m);
    logic [ARQ+1:0] t, mm;
    mm = {2'b00, m};
    t  = {acc[ARQ:0], 1'b0};
    if (t >= mm) t = t - mm;
    if (bb) t = t + {2'b00, a};
    if (t >= mm) t = t - mm;
    return t;
  endfunction

  assign mul_a   = (state_q == S_ESQR) ? r_q : a_q;
  assign mul_bit = (state_q == S_MUL) ? b_q[cnt_q] : r_q[cnt_q];
  assign step    = mm_step(acc_q, mul_a, mul_bit, m_q);
  assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w  = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    r_d     = r_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          op_d   = ALU_Contrl;
          a_d    = data1;
          b_d    = data2;
          m_d    = data3;
          acc_d  = '0;
          cnt_d  = CNT_TOP;
          ecnt_d = CNT_TOP;
          if (!ALU_Contrl[1] || data3 == '0) state_d = S_WB;
          else if (ALU_Contrl == OP_MUL)     state_d = S_MUL;
          else                               state_d = S_EINIT;
        end
      end
      S_WB: begin
        // m of 0 flags an error and m of 1 forces 0, regardless of the operand preconditions.
        case (op_q)
          OP_ADD: begin
            res_d = sum_w[ARQ-1:0];
            c_d   = sum_w[ARQ];
            v_d   = (a_q[ARQ-1] == b_q[ARQ-1]) && (sum_w[ARQ-1] != a_q[ARQ-1]);
            err_d = 1'b0;
          end
          OP_SUB: begin
            res_d = diff_w[ARQ-1:0];
            c_d   = diff_w[ARQ];
            v_d   = (a_q[ARQ-1] != b_q[ARQ-1]) && (diff_w[ARQ-1] != a_q[ARQ-1]);
            err_d = 1'b0;
          end
          default: begin
            res_d = (m_q <= ARQ'(1)) ? '0 : r_q;
            c_d   = 1'b0;
            v_d   = 1'b0;
            err_d = (m_q == '0);
          end
        endcase
        z_d     = (res_d == '0);
        state_d = S_FIN;
      end
      S_MUL: begin
        acc_d = step;
        if (cnt_q == '0) begin
          r_d     = step[ARQ-1:0];
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EINIT: begin
        r_d     = (m_q == ARQ'(1)) ? '0 : ARQ'(1);
        state_d = S_ESQR;
      end
      S_ESQR: begin
        acc_d = step;
        if (cnt_q == '0) begin
          r_d     = step[ARQ-1:0];
          acc_d   = '0;
          cnt_d   = CNT_TOP;
          state_d = S_EMUL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EMUL: begin
        // The multiply always runs; only the commit depends on the exponent bit.
        acc_d = step;
        if (cnt_q == '0) begin
          if (b_q[ecnt_q]) r_d = step[ARQ-1:0];
          acc_d = '0;
          cnt_d = CNT_TOP;
          if (ecnt_q == '0) begin
            state_d = S_WB;
          end else begin
            ecnt_d  = ecnt_q - 1'b1;
            state_d = S_ESQR;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    b_q    <= b_d;
    m_q    <= m_d;
    r_q    <= r_d;
    acc_q  <= acc_d;
    cnt_q  <= cnt_d;
    ecnt_q <= ecnt_d;
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign ALU_Result = res_q;
  assign z          = z_q;
  assign c          = c_q;
  assign v          = v_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rsa_alu_seq.sv
// Scoreboard bench for rsa_alu_seq: a driver pushes reference-model expectations,
// a monitor pops and compares result, flags and latency on every done pulse.
module tb_rsa_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] d1 = '0, d2 = '0, d3 = '0;
  logic         busy, done, z, c, v, err;
  logic [W-1:0] res;

  rsa_alu_seq #(.ARQ(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_Contrl(op),
    .data1(d1), .data2(d2), .data3(d3),
    .busy(busy), .done(done), .ALU_Result(res),
    .z(z), .c(c), .v(v), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic, flags {z,c,v,err}, latency from the op rules.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] m);
    exp_t   e;
    longint r, mm;
    int     s;
    logic   cf, vf, ef;
    cf = 1'b0; vf = 1'b0; ef = 1'b0;
    mm = longint'(m);
    e.acc = 0;
    e.lat = 1;
    r = 0;
    case (o)
      2'b00: begin
        r  = longint'(a) + longint'(b);
        cf = (r >= (64'sd1 << W));
        s  = int'($signed(a)) + int'($signed(b));
        vf = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
      end
      2'b01: begin
        r  = longint'(a) - longint'(b);
        cf = (a < b);
        s  = int'($signed(a)) - int'($signed(b));
        vf = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
      end
      default: begin
        if (m == '0) begin
          ef = 1'b1;
          r  = 0;
        end else if (o == 2'b11) begin
          r = (longint'(a) * longint'(b)) % mm;
          e.lat = W + 1;
        end else begin
          r = (mm == 1) ? 0 : 1;
          for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (b[i]) r = (r * longint'(a)) % mm;
          end
          e.lat = 2 * W * W + 2;
        end
      end
    endcase
    e.res = r[W-1:0];
    e.fl  = {(e.res == '0), cf, vf, ef};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no pending op");
      end else begin
        mon_e = sb.pop_front();
        chk("result", 64'(res), 64'(mon_e.res));
        chk("flags_zcv_err", 64'({z, c, v, err}), 64'(mon_e.fl));
        chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] m);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!(busy === 1'b0 || done === 1'b1)) begin
      t++;
      if (t > 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL issue_timeout: got busy=%0b after %0d cycles, expected idle", busy, t);
        return;
      end
      @(negedge clk);
    end
    op = o; d1 = a; d2 = b; d3 = m;
    start = 1'b1;
    e = model(o, a, b, m);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending ops, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] m, a, b;
    int n;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(res), 64'd0);
    chk("rst_flags", 64'({z, c, v, err}), 64'd0);
    rst = 1'b1;

    issue(2'b00, 16'hFFFF, 16'h0001, 16'h0000);
    issue(2'b00, 16'h7FFF, 16'h0001, 16'h0000);
    issue(2'b01, 16'd5, 16'd7, 16'h0000);
    issue(2'b11, 16'd7, 16'd9, 16'd10);
    issue(2'b10, 16'd4, 16'd13, 16'd497);
    issue(2'b10, 16'd4, 16'd0, 16'd497);
    issue(2'b10, 16'd5, 16'h00FF, 16'd1);
    issue(2'b11, 16'd3, 16'd5, 16'd0);
    issue(2'b10, 16'd3, 16'd5, 16'd0);
    issue(2'b11, 16'd0, 16'd0, 16'd1);
    drain();

    issue(2'b00, 16'h1234, 16'h4321, 16'h0000);
    issue(2'b01, 16'h8000, 16'h0001, 16'h0000);
    issue(2'b11, 16'd100, 16'd200, 16'd257);
    drain();

    // Start pulses during a modexp must be dropped, not queued.
    issue(2'b10, 16'd4, 16'd13, 16'd497);
    repeat (50) @(negedge clk);
    op = 2'b00; d1 = 16'h1111; d2 = 16'h2222; d3 = 16'h0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain();

    // One-cycle reset in the middle of a modexp aborts it silently.
    issue(2'b10, 16'd3, 16'hBEEF, 16'd1009);
    repeat (200) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(res), 64'd0);
    chk("midrst_flags", 64'({z, c, v, err}), 64'd0);
    rst = 1'b1;
    repeat (600) @(negedge clk);
    issue(2'b11, 16'd1234, 16'd4321, 16'd65521);
    drain();

    for (int k = 0; k < 4; k++) begin
      n = (k == 2) ? 30 : ((k == 3) ? 100 : 150);
      for (int i = 0; i < n; i++) begin
        m = W'($urandom_range(1, 65535));
        a = W'($urandom);
        b = W'($urandom);
        if (k >= 2) a = W'(32'(a) % 32'(m));
        if (k == 3) b = W'(32'(b) % 32'(m));
        issue(2'(k), a, b, m);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
